// File: rtl/avm_cmd_master.sv
// avm_cmd_master: single-outstanding command-to-Avalon-MM master bridge.
//
// Takes one read/write command on a valid/ready stream, runs it as one
// Avalon-MM transfer (honouring waitrequest and a fixed slave read latency),
// and returns a single response on a valid/ready stream.
//
// Parameters:
//   ADDR_W        Avalon word-address width
//   READ_LATENCY  fixed slave read latency, 0..3
//   TIMEOUT       waitrequest cycle limit, 1..65535 (only with AVM_TIMEOUT_EN)
//
// Optional feature macro: AVM_TIMEOUT_EN
//   defined   -> a stuck waitrequest aborts the transfer after TIMEOUT
//                cycles with aso_rsp_error = 1
//   undefined -> BUS waits forever, aso_rsp_error is tied to 0
//
// Ports:
//   csi_MCLK_clk, rsi_MRST_reset        clock, async active-high reset
//   asi_cmd_*                           command stream (valid/ready)
//   aso_rsp_*                           response stream (valid/ready)
//   avm_*                               Avalon-MM master (requests registered)
module avm_cmd_master #(
  parameter int ADDR_W       = 3,
  parameter int READ_LATENCY = 1,
  parameter int TIMEOUT      = 255
) (
  input  logic              csi_MCLK_clk,
  input  logic              rsi_MRST_reset,
  input  logic              asi_cmd_valid,
  output logic              asi_cmd_ready,
  input  logic              asi_cmd_write,
  input  logic [ADDR_W-1:0] asi_cmd_address,
  input  logic [31:0]       asi_cmd_writedata,
  input  logic [3:0]        asi_cmd_byteenable,
  output logic              aso_rsp_valid,
  input  logic              aso_rsp_ready,
  output logic [31:0]       aso_rsp_data,
  output logic              aso_rsp_error,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [31:0]       avm_writedata,
  output logic [3:0]        avm_byteenable,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_waitrequest
);

  // Out-of-range parameters elaborate to an empty, named marker block so a
  // bad configuration is visible in the hierarchy.
  if (READ_LATENCY < 0 || READ_LATENCY > 3) begin : g_bad_read_latency
  end
  if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
  end

  typedef enum logic [1:0] {IDLE, BUS, RDWAIT, RESP} state_t;

  localparam logic [1:0] LAT_LAST = 2'(READ_LATENCY > 0 ? READ_LATENCY - 1 : 0);

  state_t              state, state_d;
  logic [1:0]          lat_cnt, lat_cnt_d;
  logic [ADDR_W-1:0]   addr_d;
  logic [31:0]         wdata_d, rdata_d;
  logic [3:0]          be_d;
  logic                rd_d, wr_d, rsp_valid_d;

  // Ready is combinational so it drops the instant reset asserts.
  assign asi_cmd_ready = (state == IDLE) && !rsi_MRST_reset;

`ifdef AVM_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] tmo_cnt, tmo_cnt_d;
  logic        rsp_err, rsp_err_d;
  assign aso_rsp_error = rsp_err;
`else
  assign aso_rsp_error = 1'b0;
`endif

  always_ff @(posedge csi_MCLK_clk or posedge rsi_MRST_reset) begin
    if (rsi_MRST_reset) begin
      state          <= IDLE;
      lat_cnt        <= '0;
      avm_address    <= '0;
      avm_read       <= 1'b0;
      avm_write      <= 1'b0;
      avm_writedata  <= '0;
      avm_byteenable <= '0;
      aso_rsp_valid  <= 1'b0;
      aso_rsp_data   <= '0;
`ifdef AVM_TIMEOUT_EN
      tmo_cnt        <= '0;
      rsp_err        <= 1'b0;
`endif
    end else begin
      state          <= state_d;
      lat_cnt        <= lat_cnt_d;
      avm_address    <= addr_d;
      avm_read       <= rd_d;
      avm_write      <= wr_d;
      avm_writedata  <= wdata_d;
      avm_byteenable <= be_d;
      aso_rsp_valid  <= rsp_valid_d;
      aso_rsp_data   <= rdata_d;
`ifdef AVM_TIMEOUT_EN
      tmo_cnt        <= tmo_cnt_d;
      rsp_err        <= rsp_err_d;
`endif
    end
  end

  always_comb begin
    state_d     = state;
    lat_cnt_d   = lat_cnt;
    addr_d      = avm_address;
    rd_d        = avm_read;
    wr_d        = avm_write;
    wdata_d     = avm_writedata;
    be_d        = avm_byteenable;
    rsp_valid_d = aso_rsp_valid;
    rdata_d     = aso_rsp_data;
`ifdef AVM_TIMEOUT_EN
    tmo_cnt_d   = tmo_cnt;
    rsp_err_d   = rsp_err;
`endif

    case (state)
      IDLE: begin
        if (asi_cmd_valid && asi_cmd_ready) begin
          addr_d  = asi_cmd_address;
          wdata_d = asi_cmd_writedata;
          be_d    = asi_cmd_write ? asi_cmd_byteenable : 4'hF;
          rd_d    = !asi_cmd_write;
          wr_d    = asi_cmd_write;
          state_d = BUS;
`ifdef AVM_TIMEOUT_EN
          tmo_cnt_d = '0;
`endif
        end
      end

      BUS: begin
        if (!avm_waitrequest) begin
          // Slave accepted this cycle; request strobes drop next cycle.
          rd_d = 1'b0;
          wr_d = 1'b0;
`ifdef AVM_TIMEOUT_EN
          rsp_err_d = 1'b0;
`endif
          if (avm_write) begin
            rdata_d     = '0;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
          end else if (READ_LATENCY == 0) begin
            rdata_d     = avm_readdata;
            rsp_valid_d = 1'b1;
            state_d     = RESP;
          end else begin
            lat_cnt_d = '0;
            state_d   = RDWAIT;
          end
        end
`ifdef AVM_TIMEOUT_EN
        else if (tmo_cnt == TMO_LAST) begin
          // TIMEOUT consecutive wait cycles seen: abandon the bus transfer.
          rd_d        = 1'b0;
          wr_d        = 1'b0;
          rdata_d     = '0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          tmo_cnt_d = tmo_cnt + 16'd1;
        end
`endif
      end

      RDWAIT: begin
        // lat_cnt counts cycles after accept; data is valid in the last one.
        if (lat_cnt == LAT_LAST) begin
          rdata_d     = avm_readdata;
          rsp_valid_d = 1'b1;
          state_d     = RESP;
        end else begin
          lat_cnt_d = lat_cnt + 2'd1;
        end
      end

      RESP: begin
        if (aso_rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_avm_cmd_master.sv
// Self-checking bench for avm_cmd_master. The slave side is a word memory
// with byte-enable writes; expected read data and response timing come from
// that memory and the command/latency rules, cycle by cycle.
module tb_avm_cmd_master;

  localparam int ADDR_W = 3;
  localparam int LAT    = 1;
  localparam int TMO    = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid, cmd_ready, cmd_write;
  logic [ADDR_W-1:0] cmd_address;
  logic [31:0]       cmd_writedata;
  logic [3:0]        cmd_byteenable;
  logic              rsp_valid, rsp_ready, rsp_error;
  logic [31:0]       rsp_data;
  logic [ADDR_W-1:0] avm_address;
  logic              avm_read, avm_write, avm_waitrequest;
  logic [31:0]       avm_writedata, avm_readdata;
  logic [3:0]        avm_byteenable;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] mem [0:(1<<ADDR_W)-1];

  always #5 clk = ~clk;

  avm_cmd_master #(.ADDR_W(ADDR_W), .READ_LATENCY(LAT), .TIMEOUT(TMO)) dut (
    .csi_MCLK_clk      (clk),
    .rsi_MRST_reset    (rst),
    .asi_cmd_valid     (cmd_valid),
    .asi_cmd_ready     (cmd_ready),
    .asi_cmd_write     (cmd_write),
    .asi_cmd_address   (cmd_address),
    .asi_cmd_writedata (cmd_writedata),
    .asi_cmd_byteenable(cmd_byteenable),
    .aso_rsp_valid     (rsp_valid),
    .aso_rsp_ready     (rsp_ready),
    .aso_rsp_data      (rsp_data),
    .aso_rsp_error     (rsp_error),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_writedata     (avm_writedata),
    .avm_byteenable    (avm_byteenable),
    .avm_readdata      (avm_readdata),
    .avm_waitrequest   (avm_waitrequest)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // One full command/response round trip. Called at a negedge with the DUT idle.
  task automatic do_txn(input bit wr, input logic [ADDR_W-1:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input int stall, input int hold);
    logic [31:0] exp_data;
    logic [3:0]  exp_be;
    exp_be = wr ? be : 4'hF;
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1; cmd_write = wr; cmd_address = a; cmd_writedata = wd; cmd_byteenable = be;
    avm_readdata = $urandom;
    tick();                                   // edge t0: accepted
    cmd_valid = 0; cmd_write = $urandom; cmd_address = $urandom;
    cmd_writedata = $urandom; cmd_byteenable = $urandom;
    // BUS: held for stall wait cycles plus the accept cycle
    for (int i = 0; i <= stall; i++) begin
      chk("avm_read_bus", avm_read, !wr);
      chk("avm_write_bus", avm_write, wr);
      chk("avm_address", avm_address, a);
      chk("avm_writedata", avm_writedata, wd);
      chk("avm_byteenable", avm_byteenable, exp_be);
      chk("rsp_valid_early", rsp_valid, 0);
      chk("cmd_ready_busy", cmd_ready, 0);
      avm_waitrequest = (i < stall);
      avm_readdata = (!wr && LAT == 0 && i == stall) ? mem[a] : $urandom;
      tick();
    end
    avm_waitrequest = $urandom;
    exp_data = wr ? 32'h0 : mem[a];
    if (wr)
      for (int b = 0; b < 4; b++)
        if (be[b]) mem[a][8*b +: 8] = wd[8*b +: 8];
    if (!wr)
      for (int k = 1; k <= LAT; k++) begin
        chk("avm_idle_rdwait", {avm_read, avm_write}, 0);
        chk("rsp_valid_rdwait", rsp_valid, 0);
        avm_readdata = (k == LAT) ? mem[a] : $urandom;
        tick();
      end
    // RESP: held until handshake; a pending command must not be taken
    for (int j = 0; j <= hold; j++) begin
      chk("rsp_valid", rsp_valid, 1);
      chk("rsp_data", rsp_data, exp_data);
      chk("rsp_error", rsp_error, 0);
      chk("cmd_ready_resp", cmd_ready, 0);
      chk("avm_idle_resp", {avm_read, avm_write}, 0);
      rsp_ready = (j == hold);
      cmd_valid = (j < hold);
      avm_readdata = $urandom;
      tick();
    end
    rsp_ready = 0; cmd_valid = 0;
    chk("rsp_valid_after", rsp_valid, 0);
    chk("cmd_ready_after", cmd_ready, 1);
  endtask

  initial begin
    for (int i = 0; i < (1<<ADDR_W); i++) mem[i] = $urandom;
    mem[4] = 32'h0000005A;
    rst = 1; cmd_valid = 0; cmd_write = 0; cmd_address = '0; cmd_writedata = '0;
    cmd_byteenable = '0; rsp_ready = 0; avm_readdata = '0; avm_waitrequest = 0;
    repeat (2) @(negedge clk);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_avm_rw", {avm_read, avm_write}, 0);
    chk("rst_avm_address", avm_address, 0);
    chk("rst_avm_writedata", avm_writedata, 0);
    chk("rst_avm_byteenable", avm_byteenable, 0);
    chk("rst_rsp", {rsp_valid, rsp_error}, 0);
    chk("rst_rsp_data", rsp_data, 0);
    rst = 0;
    tick();
    chk("cmd_ready_post_rst", cmd_ready, 1);

    // Directed cases
    do_txn(1, 3'd2, 32'h000000A5, 4'h1, 0, 0);   // simple write
    do_txn(0, 3'd4, 32'h0, 4'h0, 0, 0);          // read 0x5A
    do_txn(1, 3'd5, 32'hDEADBEEF, 4'hF, 3, 0);   // write, 3 wait cycles
    do_txn(0, 3'd2, 32'h0, 4'h0, 0, 5);          // read merged word, slow consumer
    do_txn(0, 3'd5, 32'h0, 4'h0, 2, 1);

    // Random traffic
    for (int n = 0; n < 40; n++)
      do_txn($urandom_range(0, 1), ADDR_W'($urandom), $urandom, 4'($urandom),
             $urandom_range(0, 3), $urandom_range(0, 2));

`ifdef AVM_TIMEOUT_EN
    // Stuck waitrequest on a read: strobe high for TMO cycles, then error
    cmd_valid = 1; cmd_write = 0; cmd_address = 3'd6;
    tick();
    cmd_valid = 0;
    avm_waitrequest = 1;
    for (int i = 0; i < TMO; i++) begin
      chk("tmo_read_high", avm_read, 1);
      chk("tmo_rsp_valid_low", rsp_valid, 0);
      avm_readdata = $urandom;
      tick();
    end
    chk("tmo_read_drop", avm_read, 0);
    chk("tmo_rsp_valid", rsp_valid, 1);
    chk("tmo_rsp_error", rsp_error, 1);
    chk("tmo_rsp_data", rsp_data, 0);
    rsp_ready = 1;
    tick();
    rsp_ready = 0; avm_waitrequest = 0;
    chk("tmo_idle", cmd_ready, 1);
    do_txn(0, 3'd4, 32'h0, 4'h0, 0, 0);          // error flag cleared afterwards
`endif

    // Reset during a stalled write: strobe drops without a clock edge
    cmd_valid = 1; cmd_write = 1; cmd_address = 3'd1; cmd_writedata = 32'h12345678;
    cmd_byteenable = 4'h3;
    tick();
    cmd_valid = 0;
    avm_waitrequest = 1;
    chk("rst_mid_write_active", avm_write, 1);
    #2 rst = 1;
    #1;
    chk("rst_mid_write_drop", avm_write, 0);
    chk("rst_mid_address", avm_address, 0);
    chk("rst_mid_cmd_ready", cmd_ready, 0);
    @(negedge clk);
    rst = 0; avm_waitrequest = 0;
    tick();
    chk("rst_mid_cmd_ready_rel", cmd_ready, 1);
    for (int i = 0; i < 3; i++) begin
      chk("rst_mid_no_rsp", rsp_valid, 0);
      tick();
    end
    do_txn(0, 3'd1, 32'h0, 4'h0, 1, 0);          // abandoned write left memory untouched

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/avm_cmd_master.md
AVM_CMD_MASTER -- requirements
Module: avm_cmd_master

Interface
REQ-001 Parameter ADDR_W, default 3: Avalon word-address width.
REQ-002 Parameter READ_LATENCY, default 1: fixed slave read latency in cycles; legal range 0..3.
REQ-003 Parameter TIMEOUT, default 255: waitrequest cycle limit; range 1..65535; used only when AVM_TIMEOUT_EN is defined.
REQ-004 csi_MCLK_clk  in  1  sole clock; all logic rising-edge.
REQ-005 rsi_MRST_reset  in  1  asynchronous, active-high reset.
REQ-006 asi_cmd_valid  in  1  command present.
REQ-007 asi_cmd_ready  out  1  command accepted when valid and ready are both high at a rising edge.
REQ-008 asi_cmd_write  in  1  1 = write, 0 = read.
REQ-009 asi_cmd_address  in  ADDR_W  target word address.
REQ-010 asi_cmd_writedata  in  32  write data.
REQ-011 asi_cmd_byteenable  in  4  write byte enables.
REQ-012 aso_rsp_valid  out  1  response present.
REQ-013 aso_rsp_ready  in  1  response consumed when valid and ready are both high at a rising edge.
REQ-014 aso_rsp_data  out  32  read data; 0 for writes.
REQ-015 aso_rsp_error  out  1  1 = transfer timed out.
REQ-016 avm_address, avm_read, avm_write, avm_writedata[31:0], avm_byteenable[3:0]  out  Avalon-MM master request, all registered.
REQ-017 avm_readdata  in  32; avm_waitrequest  in  1  Avalon-MM slave returns.

Function
REQ-018 States SHALL be IDLE, BUS, RDWAIT and RESP.
REQ-019 asi_cmd_ready SHALL be 1 only in IDLE with reset deasserted.
REQ-020 Command accept SHALL register address, writedata and byteenable (byteenable = 4'hF for reads), then enter BUS.
REQ-021 BUS SHALL assert exactly one of avm_read and avm_write, with all request outputs held stable while avm_waitrequest = 1.
REQ-022 A BUS cycle with avm_waitrequest = 0 is the accept cycle; avm_read and avm_write SHALL be 0 in the following cycle.
REQ-023 Write accept SHALL go to RESP with aso_rsp_data = 0 and aso_rsp_error = 0.
REQ-024 Read with READ_LATENCY = 0 SHALL capture avm_readdata in the accept cycle and go to RESP.
REQ-025 Read with READ_LATENCY = N > 0 SHALL go to RDWAIT, capture avm_readdata at the end of the Nth cycle after accept, then go to RESP.
REQ-026 RESP SHALL hold aso_rsp_valid = 1 with data and error stable until the handshake, then return to IDLE.
REQ-027 No-wait latency: command accept at edge t0; avm_* active in cycle t0+1; aso_rsp_valid in cycle t0+2 for writes and t0+2+READ_LATENCY for reads.
REQ-028 Only one transfer SHALL be outstanding; no new command is accepted before the response handshake.
REQ-029 avm_readdata SHALL be ignored outside the capture cycle.

Reset
REQ-030 Reset SHALL immediately force state IDLE and set avm_read, avm_write, aso_rsp_valid and aso_rsp_error to 0, and avm_address, avm_writedata, avm_byteenable and aso_rsp_data to 0.
REQ-031 Reset mid-transfer SHALL abandon the transfer without producing a response.
REQ-032 asi_cmd_ready SHALL rise in the first cycle after reset release.

Configuration
REQ-033 Macro AVM_TIMEOUT_EN defined: a counter SHALL count BUS cycles with waitrequest = 1; after TIMEOUT consecutive such cycles, avm_read/avm_write SHALL drop next cycle and RESP SHALL be entered with aso_rsp_error = 1 and aso_rsp_data = 0.
REQ-034 AVM_TIMEOUT_EN undefined: BUS waits indefinitely, no counter logic exists, and aso_rsp_error is constant 0.

Verification
REQ-035 Write: addr 2, data 0x000000A5, be 0x1, waitrequest 0 -> avm_write high for one cycle with those values; rsp_valid at t0+2 with data 0 and error 0.
REQ-036 Read: READ_LATENCY 1, addr 4; slave model drives 0x0000005A one cycle after accept -> aso_rsp_data = 0x0000005A at t0+3.
REQ-037 Write with waitrequest high for 3 cycles -> avm_write and request fields stable for 4 cycles; rsp_valid at t0+5.
REQ-038 rsp_ready low for 5 cycles -> rsp_valid and data stable and cmd_ready 0 throughout; next command accepted in the cycle after the handshake.
REQ-039 AVM_TIMEOUT_EN with TIMEOUT 4 and waitrequest stuck at 1 on a read -> avm_read deasserts after 4 wait cycles; response has error 1 and data 0.
REQ-040 Reset asserted during BUS with waitrequest 1 -> avm_write 0 with no clock edge needed; no response; cmd_ready 1 the cycle after release.
